// File: rtl/axi4_lite_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg / axi4_lite_if
// Description : Shared AXI4-Lite bus configuration type and the AXI4-Lite
//               interface with master and slave modports. A zero field in the
//               configuration selects the default width (32-bit address,
//               4-byte data).
// Revision    : 1.0 - initial release
// ============================================================================

package axi4_lite_pkg;

  // A = address bits, N = data bytes
  typedef struct packed {
    int A;
    int N;
  } axi4_lite_cfg_t;

  function automatic int addr_w(input axi4_lite_cfg_t c);
    return (c.A > 0) ? c.A : 32;
  endfunction

  function automatic int strb_w(input axi4_lite_cfg_t c);
    return (c.N > 0) ? c.N : 4;
  endfunction

  function automatic int data_w(input axi4_lite_cfg_t c);
    return strb_w(c) * 8;
  endfunction

endpackage

interface axi4_lite_if #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C = '{default: 0}
);
  localparam int AW = axi4_lite_pkg::addr_w(C);
  localparam int DW = axi4_lite_pkg::data_w(C);
  localparam int SW = axi4_lite_pkg::strb_w(C);

  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

`default_nettype wire

// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_cmd_master
// Description : Single-outstanding AXI4-Lite master driven by a simple
//               command/response port. Writes issue AW and W together and
//               drop each valid independently after its handshake; reads
//               issue AR then wait on R. Each completion yields a one-cycle
//               rsp_valid pulse with held response data.
//               Optional feature macro: AXI4_LITE_CMD_TIMEOUT_EN adds an
//               in-flight cycle counter that aborts a stuck transaction.
// Revision    : 1.0 - initial release
// ============================================================================

module axi4_lite_cmd_master #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C = '{default: 0},
  parameter int TIMEOUT_W = 8
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  cmd_write,
  input  logic [axi4_lite_pkg::addr_w(C)-1:0]   cmd_addr,
  input  logic [axi4_lite_pkg::data_w(C)-1:0]   cmd_wdata,
  input  logic [axi4_lite_pkg::strb_w(C)-1:0]   cmd_wstrb,
  output logic                                  rsp_valid,
  output logic [axi4_lite_pkg::data_w(C)-1:0]   rsp_rdata,
  output logic                                  rsp_error,
  output logic                                  rsp_timeout,
  axi4_lite_if.master                           axi4_m
);

  localparam int AW = axi4_lite_pkg::addr_w(C);
  localparam int DW = axi4_lite_pkg::data_w(C);
  localparam int SW = axi4_lite_pkg::strb_w(C);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD      = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          aw_pend;
  logic          w_pend;
  logic          accept;
  logic          aw_ok;
  logic          w_ok;
  logic          b_done;
  logic          r_done;
  logic          tmo_expire;
  logic          tmo_hit;
  logic          unused_resp_lsb;

  // Reject a zero or oversized counter width at elaboration.
  if (TIMEOUT_W < 1 || TIMEOUT_W > 31) begin : g_bad_timeout_w
    $error("axi4_lite_cmd_master: TIMEOUT_W must be in 1..31");
  end

  // Ready is gated by reset so it reads low while aresetn is asserted.
  assign cmd_ready = aresetn && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // A channel counts as done once its valid has already dropped or it
  // handshakes this cycle.
  assign aw_ok  = !aw_pend || axi4_m.awready;
  assign w_ok   = !w_pend  || axi4_m.wready;
  assign b_done = (state == WR_RESP) && axi4_m.bvalid;
  assign r_done = (state == RD_RESP) && axi4_m.rvalid;

  // A real completion on the expiry cycle wins over the abort.
  assign tmo_hit = tmo_expire && !b_done && !r_done;

  // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp_lsb = axi4_m.bresp[0] ^ axi4_m.rresp[0];

  // Address, data and protection come straight from the captured command.
  assign axi4_m.awaddr = addr_q;
  assign axi4_m.araddr = addr_q;
  assign axi4_m.awprot = 3'b000;
  assign axi4_m.arprot = 3'b000;
  assign axi4_m.wdata  = wdata_q;
  assign axi4_m.wstrb  = wstrb_q;

`ifdef AXI4_LITE_CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  logic [TIMEOUT_W-1:0] tcnt_inc;

  assign tcnt_inc = tcnt + 1'b1;
  // Expiry fires on the edge where the counter reaches all-ones.
  assign tmo_expire = (state != IDLE) && (tcnt_inc == {TIMEOUT_W{1'b1}});

  // Count cycles spent outside IDLE, restarting on every accepted command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tcnt <= '0;
    end else if (accept) begin
      tcnt <= '0;
    end else if (state != IDLE) begin
      tcnt <= tcnt_inc;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and AXI handshake outputs.
  always_comb begin
    state_nxt      = state;
    axi4_m.awvalid = 1'b0;
    axi4_m.wvalid  = 1'b0;
    axi4_m.bready  = 1'b0;
    axi4_m.arvalid = 1'b0;
    axi4_m.rready  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = cmd_write ? WR : RD;
        end
      end
      WR: begin
        axi4_m.awvalid = aw_pend;
        axi4_m.wvalid  = w_pend;
        if (aw_ok && w_ok) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        axi4_m.bready = 1'b1;
        if (axi4_m.bvalid) begin
          state_nxt = IDLE;
        end
      end
      RD: begin
        axi4_m.arvalid = 1'b1;
        if (axi4_m.arready) begin
          state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        axi4_m.rready = 1'b1;
        if (axi4_m.rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  // Command capture and per-channel valid tracking for the write phase.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
      aw_pend <= cmd_write;
      w_pend  <= cmd_write;
    end else if (state == WR) begin
      if (axi4_m.awready) begin
        aw_pend <= 1'b0;
      end
      if (axi4_m.wready) begin
        w_pend <= 1'b0;
      end
    end
  end

  // Response pulse; payload fields hold until the next completion.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (b_done) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_error   <= axi4_m.bresp[1];
        rsp_timeout <= 1'b0;
      end else if (r_done) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= axi4_m.rdata;
        rsp_error   <= axi4_m.rresp[1];
        rsp_timeout <= 1'b0;
      end else if (tmo_hit) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
